// File: rtl/sub_bytes_iter.sv
`default_nettype none
// ============================================================================
// Module      : sub_bytes_iter
// Description : Iterative AES SubBytes / InvSubBytes engine, LANES bytes per
//               clock through shared S-box lanes, valid/ready on both sides.
//               Optional macro SUBBYTES_ABORT_EN adds an abort input.
// Revision    : 1.0 - initial release
// ============================================================================
module sub_bytes_iter #(
    parameter int LANES = 4,
    parameter int CNT_W = (LANES >= 16) ? 1 : $clog2(16 / LANES)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_mode,
    input  logic [127:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
`ifdef SUBBYTES_ABORT_EN
    input  logic         abort,
`endif
    output logic         busy
);

    localparam int             c_chunks = 16 / LANES;
    localparam logic [CNT_W-1:0] c_last = CNT_W'(c_chunks - 1);

    if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8 && LANES != 16) begin : g_bad_lanes
        $error("sub_bytes_iter: LANES must be 1, 2, 4, 8 or 16");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_mode;
    logic [127:0]        r_work;

    logic [LANES-1:0][7:0] w_lane_in;
    logic [LANES-1:0][7:0] w_lane_out;
    logic [127:0]          w_work_next;
    logic                  w_abort;

`ifdef SUBBYTES_ABORT_EN
    assign w_abort = abort;
`else
    assign w_abort = 1'b0;
`endif

    // GF(2^8) arithmetic modulo x^8+x^4+x^3+x+1
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] x;
        acc = 8'h00;
        x   = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return acc;
    endfunction

    // a^254 is the multiplicative inverse, and maps 0 to 0 as the S-box requires
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] acc;
        sq  = a;
        acc = 8'h01;
        for (int i = 0; i < 7; i++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        return acc;
    endfunction

    function automatic logic [7:0] fwd_affine(input logic [7:0] b);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                 ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_affine(input logic [7:0] b);
        return {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
    endfunction

    // One inversion core shared by both directions; affine stages placed per mode
    function automatic logic [7:0] sbox_lane(input logic [7:0] b, input logic inv);
        logic [7:0] pre;
        logic [7:0] mid;
        pre = inv ? inv_affine(b) : b;
        mid = gf_inv(pre);
        return inv ? mid : fwd_affine(mid);
    endfunction

    always_comb begin
        w_lane_in = '0;
        for (int k = 0; k < 16; k++) begin
            if (CNT_W'(k / LANES) == r_cnt) begin
                w_lane_in[k % LANES] = r_work[127 - 8*k -: 8];
            end
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        assign w_lane_out[l] = sbox_lane(w_lane_in[l], r_mode);
    end

    always_comb begin
        w_work_next = r_work;
        for (int k = 0; k < 16; k++) begin
            if (CNT_W'(k / LANES) == r_cnt) begin
                w_work_next[127 - 8*k -: 8] = w_lane_out[k % LANES];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_mode    <= 1'b0;
            r_work    <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid && in_ready) begin
                        r_work   <= in_data;
                        r_mode   <= in_mode;
                        r_cnt    <= '0;
                        r_state  <= S_RUN;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (w_abort) begin
                        r_state  <= S_IDLE;
                        r_cnt    <= '0;
                        in_ready <= 1'b1;
                        busy     <= 1'b0;
                    end else begin
                        r_work <= w_work_next;
                        if (r_cnt == c_last) begin
                            r_cnt     <= '0;
                            r_state   <= S_DONE;
                            out_valid <= 1'b1;
                            out_data  <= w_work_next;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                end
                S_DONE: begin
                    // abort wins over a simultaneous output handshake
                    if (w_abort || out_ready) begin
                        r_state   <= S_IDLE;
                        r_cnt     <= '0;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_cnt     <= '0;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sub_bytes_iter.sv
`default_nettype none
// ============================================================================
// Module      : tb_sub_bytes_iter
// Description : Scoreboard bench for sub_bytes_iter; table-based S-box model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sub_bytes_iter;

    localparam int MAIN_LANES = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n, in_valid, in_mode, out_ready, abort_s;
    logic         in_ready, out_valid, busy;
    logic [127:0] in_data, out_data;
    logic         aux_rst_n;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int rdy_mode = 2;      // 0 random, 1 held low, 2 held high
    int aux_done_cnt = 0;

    logic [7:0]   sbox  [256];
    logic [7:0]   isbox [256];
    logic [127:0] exp_q [$];

    sub_bytes_iter #(.LANES(MAIN_LANES)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_mode(in_mode), .in_data(in_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data),
`ifdef SUBBYTES_ABORT_EN
        .abort(abort_s),
`endif
        .busy(busy)
    );

    function automatic logic [7:0] rol8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    // Walk the multiplicative group with generator 3 and its inverse in step
    task automatic build_tables();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b00};
            q = q ^ {q[3:0], 4'h0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ rol8(q, 1) ^ rol8(q, 2) ^ rol8(q, 3) ^ rol8(q, 4);
            sbox[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sbox[0] = 8'h63;
        for (int i = 0; i < 256; i++) isbox[sbox[i]] = 8'(i);
    endtask

    function automatic logic [127:0] ref_sub(input logic [127:0] d, input logic m);
        logic [127:0] r;
        for (int k = 0; k < 16; k++)
            r[127 - 8*k -: 8] = m ? isbox[d[127 - 8*k -: 8]] : sbox[d[127 - 8*k -: 8]];
        return r;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    task automatic fail_timeout(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: got timeout expected event", name);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (rdy_mode == 1)      out_ready = 1'b0;
            else if (rdy_mode == 2) out_ready = 1'b1;
            else                    out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: latency of each result and data against the scoreboard queue
    initial begin : monitor
        logic prev_ov;
        logic [127:0] e;
        prev_ov = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_ov = 1'b0;
            end else begin
                if (in_valid && in_ready) acc_cyc = cyc + 1;
                if (out_valid && !prev_ov)
                    chk("latency", 128'(cyc - acc_cyc), 128'(16 / MAIN_LANES));
                if (out_valid && out_ready && !abort_s) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL unexpected_output: got %h expected none", out_data);
                    end else begin
                        e = exp_q.pop_front();
                        chk("data", out_data, e);
                    end
                end
                prev_ov = out_valid;
            end
        end
    end

    // Called and returns 1 time unit after a rising edge
    task automatic send(input logic [127:0] d, input logic m, input logic [127:0] expv);
        int t;
        bit ok;
        in_data  = d;
        in_mode  = m;
        in_valid = 1'b1;
        t  = 0;
        ok = 1'b0;
        while (!ok && t <= 200) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1;
            else t++;
        end
        if (ok) exp_q.push_back(expv);
        else    fail_timeout("accept");
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_mode  = 1'($urandom_range(0, 1));
        in_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 500) begin
            @(posedge clk); #1;
            t++;
        end
        if (exp_q.size() != 0) begin
            fail_timeout("drain");
            exp_q.delete();
        end
        @(posedge clk); #1;
    endtask

    task automatic wait_out_valid();
        int t;
        t = 0;
        @(negedge clk);
        while (!out_valid && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!out_valid) fail_timeout("out_valid");
    endtask

    initial begin
        aux_rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 aux_rst_n = 1'b1;
    end

    for (genvar g = 0; g < 4; g++) begin : g_aux
        localparam int L = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 8 : 16;
        logic         iv, ir, im, ov, bz, orr;
        logic [127:0] id, od;

        sub_bytes_iter #(.LANES(L)) u_dut (
            .clk(clk), .rst_n(aux_rst_n), .in_valid(iv), .in_ready(ir),
            .in_mode(im), .in_data(id), .out_valid(ov), .out_ready(orr),
            .out_data(od),
`ifdef SUBBYTES_ABORT_EN
            .abort(1'b0),
`endif
            .busy(bz)
        );

        initial begin
            logic [127:0] vd [4];
            logic         vm [4];
            logic [127:0] ve [4];
            int lat;
            iv = 1'b0; im = 1'b0; id = '0; orr = 1'b1;
            wait (aux_rst_n === 1'b1);
            vd[0] = '0;            vm[0] = 1'b0; ve[0] = {16{8'h63}};
            vd[1] = '0;            vm[1] = 1'b1; ve[1] = {16{8'h52}};
            vd[2] = {16{8'h53}};   vm[2] = 1'b0; ve[2] = {16{8'hED}};
            vd[3] = {$urandom(), $urandom(), $urandom(), $urandom()};
            vm[3] = 1'($urandom_range(0, 1));
            ve[3] = ref_sub(vd[3], vm[3]);
            @(posedge clk); #1;
            for (int v = 0; v < 4; v++) begin
                iv = 1'b1; id = vd[v]; im = vm[v];
                @(negedge clk);
                chk($sformatf("aux%0d_in_ready", L), 128'(ir), 128'(1));
                @(posedge clk); #1;
                iv = 1'b0; im = ~im;
                lat = 0;
                @(negedge clk);
                while (!ov && lat <= 40) begin
                    lat++;
                    @(negedge clk);
                end
                chk($sformatf("aux%0d_latency", L), 128'(lat), 128'(16 / L));
                chk($sformatf("aux%0d_data", L), od, ve[v]);
                @(posedge clk); #1;
            end
            aux_done_cnt++;
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin : stimulus
        logic [127:0] d;
        logic         m;
        int           t;
        build_tables();
        rst_n = 1'b0; in_valid = 1'b0; in_mode = 1'b0; in_data = '0; abort_s = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_busy",      128'(busy),      128'(0));
        chk("rst_out_data",  out_data,        128'(0));
        chk("rst_in_ready",  128'(in_ready),  128'(1));
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        send(128'hD4E0B81E27BFB44111985D52AEF1E530, 1'b1, 128'h19A09AE93DF4C6F8E3E28D48BE2B2A08);
        send(128'h19A09AE93DF4C6F8E3E28D48BE2B2A08, 1'b0, 128'hD4E0B81E27BFB44111985D52AEF1E530);
        send('0, 1'b0, {16{8'h63}});
        send('0, 1'b1, {16{8'h52}});
        send({16{8'h53}}, 1'b0, {16{8'hED}});
        send({16{8'hFF}}, 1'b1, ref_sub({16{8'hFF}}, 1'b1));
        wait_drain();

        rdy_mode = 0;
        for (int i = 0; i < 40; i++) begin
            d = {$urandom(), $urandom(), $urandom(), $urandom()};
            m = 1'($urandom_range(0, 1));
            send(d, m, ref_sub(d, m));
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
        wait_drain();

        // Stall in DONE with out_ready low
        rdy_mode = 1; out_ready = 1'b0;
        d = {$urandom(), $urandom(), $urandom(), $urandom()};
        m = 1'($urandom_range(0, 1));
        send(d, m, ref_sub(d, m));
        wait_out_valid();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("stall_out_valid", 128'(out_valid), 128'(1));
            chk("stall_out_data",  out_data,        ref_sub(d, m));
            chk("stall_in_ready",  128'(in_ready),  128'(0));
        end
        @(posedge clk); #1;
        rdy_mode = 2; out_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("release_in_ready",  128'(in_ready),  128'(1));
        chk("release_out_valid", 128'(out_valid), 128'(0));
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            d = {$urandom(), $urandom(), $urandom(), $urandom()};
            m = 1'(i % 2);
            send(d, m, ref_sub(d, m));
        end
        wait_drain();

        // Reset during the second RUN cycle
        d = {$urandom(), $urandom(), $urandom(), $urandom()};
        send(d, 1'b0, ref_sub(d, 1'b0));
        @(posedge clk); #1;
        rst_n = 1'b0;
        exp_q.delete();
        @(posedge clk); #1;
        @(negedge clk);
        chk("midrst_out_valid", 128'(out_valid), 128'(0));
        chk("midrst_busy",      128'(busy),      128'(0));
        chk("midrst_out_data",  out_data,        128'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        d = {$urandom(), $urandom(), $urandom(), $urandom()};
        send(d, 1'b1, ref_sub(d, 1'b1));
        wait_drain();

`ifdef SUBBYTES_ABORT_EN
        d = {$urandom(), $urandom(), $urandom(), $urandom()};
        send(d, 1'b0, ref_sub(d, 1'b0));
        @(posedge clk); #1;
        abort_s = 1'b1;
        exp_q.delete();
        @(posedge clk); #1;
        abort_s = 1'b0;
        @(negedge clk);
        chk("abort_run_out_valid", 128'(out_valid), 128'(0));
        chk("abort_run_busy",      128'(busy),      128'(0));
        chk("abort_run_in_ready",  128'(in_ready),  128'(1));
        @(posedge clk); #1;

        rdy_mode = 1; out_ready = 1'b0;
        d = {$urandom(), $urandom(), $urandom(), $urandom()};
        send(d, 1'b1, ref_sub(d, 1'b1));
        wait_out_valid();
        @(posedge clk); #1;
        abort_s = 1'b1; rdy_mode = 2; out_ready = 1'b1;
        exp_q.delete();
        @(posedge clk); #1;
        abort_s = 1'b0;
        @(negedge clk);
        chk("abort_done_out_valid", 128'(out_valid), 128'(0));
        chk("abort_done_busy",      128'(busy),      128'(0));
        @(posedge clk); #1;

        abort_s = 1'b1;
        d = {$urandom(), $urandom(), $urandom(), $urandom()};
        send(d, 1'b0, ref_sub(d, 1'b0));
        abort_s = 1'b0;
        wait_drain();
`endif

        t = 0;
        while (aux_done_cnt < 4 && t < 3000) begin
            @(posedge clk); #1;
            t++;
        end
        if (aux_done_cnt < 4) fail_timeout("aux_done");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
